// File: rtl/padding_channel_sequencer_if.sv
// rtl/padding_channel_sequencer_if.sv - feature-buffer read port and padding-stage stream bundle
// master = sequencer side, slave = feature buffer plus padding stage side.
interface padding_channel_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  pad_valid;
  logic [DATA_WIDTH-1:0] pad_data;
  logic                  pad_out_valid;

  modport master (
    output rd_en, rd_addr, pad_valid, pad_data,
    input  rd_data, pad_out_valid
  );

  modport slave (
    input  rd_en, rd_addr, pad_valid, pad_data,
    output rd_data, pad_out_valid
  );
endinterface

// File: rtl/padding_channel_sequencer.sv
// rtl/padding_channel_sequencer.sv - feeds feature-map channels into the zero-padding stage
// Reads are gated by a mirror of the padding stage's consumption so its 3-row buffer never overflows.
module padding_channel_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IMAGE_WIDTH = 4,
  parameter int NUM_CHANNEL = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int CH_WIDTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  output logic [CH_WIDTH-1:0]         o_channel,
  padding_channel_sequencer_if.master bus_io
);

  localparam int WW   = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int CAP  = 3 * IMAGE_WIDTH;
  localparam int PW   = IMAGE_WIDTH + 2;
  localparam int NPAD = PW * PW;
  localparam int IW   = $clog2(WW + 1);
  localparam int OW   = $clog2(CAP + 1);
  localparam int RW   = $clog2(PW);
  localparam int NW   = $clog2(NPAD + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CH_WIDTH-1:0]   channel_q, channel_d;
  logic [IW-1:0]         issued_q, issued_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [RW-1:0]         row_q, row_d, col_q, col_d;
  logic [NW-1:0]         out_cnt_q, out_cnt_d;
  logic                  err_q, err_d;
  logic                  rd_en_d1_q, pad_valid_q;
  logic [DATA_WIDTH-1:0] pad_data_q;

  logic                  rd_fire;
  logic                  mirror_on;
  logic                  interior;
  logic                  consume;
  logic [ADDR_WIDTH-1:0] rd_addr;

  always_comb begin
    rd_fire   = (state_q == S_FEED) && (issued_q < IW'(WW)) && (occ_q < OW'(CAP));
    rd_addr   = ADDR_WIDTH'(channel_q) * ADDR_WIDTH'(WW) + ADDR_WIDTH'(issued_q);
    mirror_on = ((state_q == S_FEED) || (state_q == S_DRAIN)) && bus_io.pad_out_valid;
    interior  = (row_q != '0) && (row_q <= RW'(IMAGE_WIDTH)) &&
                (col_q != '0) && (col_q <= RW'(IMAGE_WIDTH));
  end

  always_comb begin
    state_d   = state_q;
    channel_d = channel_q;
    issued_d  = issued_q;
    occ_d     = occ_q;
    row_d     = row_q;
    col_d     = col_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    consume   = 1'b0;

    if (rd_fire) begin
      issued_d = issued_q + 1'b1;
    end

    // Mirror the padding stage's raster walk over the padded grid.
    if (mirror_on) begin
      if (out_cnt_q == NW'(NPAD)) begin
        err_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
        if (col_q == RW'(PW - 1)) begin
          col_d = '0;
          row_d = (row_q == RW'(PW - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (interior) begin
          if (occ_q == '0) err_d = 1'b1;
          else             consume = 1'b1;
        end
      end
    end

    if (rd_fire && !consume)      occ_d = occ_q + 1'b1;
    else if (!rd_fire && consume) occ_d = occ_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          err_d     = 1'b0;
          channel_d = '0;
          issued_d  = '0;
          occ_d     = '0;
          out_cnt_d = '0;
          row_d     = '0;
          col_d     = '0;
          state_d   = S_FEED;
        end
        if (bus_io.pad_out_valid) err_d = 1'b1;
      end
      S_FEED: begin
        if (issued_d == IW'(WW)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Looking at the next count lets o_done follow the last output by one cycle.
        if (out_cnt_d == NW'(NPAD)) begin
          state_d = (channel_q == CH_WIDTH'(NUM_CHANNEL - 1)) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        channel_d = channel_q + 1'b1;
        issued_d  = '0;
        out_cnt_d = '0;
        row_d     = '0;
        col_d     = '0;
        state_d   = S_FEED;
      end
      S_DONE: begin
        if (bus_io.pad_out_valid) err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      channel_q   <= '0;
      issued_q    <= '0;
      occ_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_cnt_q   <= '0;
      err_q       <= 1'b0;
      rd_en_d1_q  <= 1'b0;
      pad_valid_q <= 1'b0;
      pad_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      channel_q   <= channel_d;
      issued_q    <= issued_d;
      occ_q       <= occ_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_cnt_q   <= out_cnt_d;
      err_q       <= err_d;
      rd_en_d1_q  <= rd_fire;
      pad_valid_q <= rd_en_d1_q;
      if (rd_en_d1_q) pad_data_q <= bus_io.rd_data;
    end
  end

  assign o_busy           = (state_q == S_FEED) || (state_q == S_DRAIN) || (state_q == S_GAP);
  assign o_done           = (state_q == S_DONE);
  assign o_err            = err_q;
  assign o_channel        = channel_q;
  assign bus_io.rd_en     = rd_fire;
  assign bus_io.rd_addr   = rd_fire ? rd_addr : '0;
  assign bus_io.pad_valid = pad_valid_q;
  assign bus_io.pad_data  = pad_data_q;

endmodule

// File: tb/tb_padding_channel_sequencer.sv
// tb/tb_padding_channel_sequencer.sv - scoreboard bench with behavioural RAM and padding stage
`timescale 1ns/1ps
module tb_padding_channel_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [1:0] ch_a;
  logic [0:0] ch_b;
  logic       sel = 1'b0;
  logic       st_out = 1'b0;
  logic       force_pv = 1'b0;

  padding_channel_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifa ();
  padding_channel_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifb ();

  padding_channel_sequencer #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .NUM_CHANNEL(3),
                              .ADDR_WIDTH(16), .CH_WIDTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
    .o_err(err_a), .o_channel(ch_a), .bus_io(ifa)
  );

  padding_channel_sequencer #(.DATA_WIDTH(32), .IMAGE_WIDTH(2), .NUM_CHANNEL(1),
                              .ADDR_WIDTH(16), .CH_WIDTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
    .o_err(err_b), .o_channel(ch_b), .bus_io(ifb)
  );

  // Feature buffer: one-cycle read latency, each word holds its own address.
  always @(posedge clk) begin
    ifa.rd_data <= 32'(ifa.rd_addr);
    ifb.rd_data <= 32'(ifb.rd_addr);
  end

  assign ifa.pad_out_valid = !sel && (st_out || force_pv);
  assign ifb.pad_out_valid =  sel && (st_out || force_pv);

  logic        m_rd_en, m_pad_valid, m_busy, m_done, m_err;
  logic [15:0] m_addr;
  logic [31:0] m_pdata;
  logic [1:0]  m_ch;
  int          mw, mc;
  always_comb begin
    m_rd_en     = sel ? ifb.rd_en     : ifa.rd_en;
    m_addr      = sel ? ifb.rd_addr   : ifa.rd_addr;
    m_pad_valid = sel ? ifb.pad_valid : ifa.pad_valid;
    m_pdata     = sel ? ifb.pad_data  : ifa.pad_data;
    m_busy      = sel ? busy_b : busy_a;
    m_done      = sel ? done_b : done_a;
    m_err       = sel ? err_b  : err_a;
    m_ch        = sel ? {1'b0, ch_b} : ch_a;
    mw          = sel ? 2 : 4;
    mc          = sel ? 1 : 3;
  end

  int     exp_addr[$], exp_pad[$], exp_done[$];
  int     nchk = 0, nerr = 0, rd_cnt = 0, dones = 0;
  longint cyc = 0, done_cyc = 0, start_cyc = 0;
  bit     err_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    nchk++;
    nerr++;
    $display("FAIL %s: event with no expectation queued", name);
  endtask

  // Padding stage: walks the (W+2)^2 grid in raster order; an interior output needs a
  // stored pixel, and a new grid's leading border waits for that grid's first pixel.
  int q[$];
  int pos = 0, grids = 0, maxq = 0, stall_pct = 0;
  bit stage_en = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pos    = 0;
      st_out = 1'b0;
    end else begin
      int pw, r, c;
      bit inter, can;
      pw    = mw + 2;
      r     = pos / pw;
      c     = pos % pw;
      inter = (r >= 1) && (r <= mw) && (c >= 1) && (c <= mw);
      can   = (inter || pos <= pw) ? (q.size() > 0) : 1'b1;
      st_out = stage_en && can && (int'($urandom_range(0, 99)) >= stall_pct);
      if (st_out) begin
        if (inter) void'(q.pop_front());
        pos++;
        if (pos == pw * pw) begin
          pos = 0;
          grids++;
        end
      end
      if (m_pad_valid) q.push_back(int'(m_pdata));
      if (q.size() > maxq) maxq = q.size();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      err_seen = err_seen | m_err;
      if (m_rd_en) begin
        rd_cnt++;
        if (exp_addr.size() == 0) fail_now("rd_unexpected");
        else begin
          int e;
          e = exp_addr.pop_front();
          check("rd_addr", m_addr, e);
          check("rd_channel", m_ch, e / (mw * mw));
        end
      end
      if (m_pad_valid) begin
        if (exp_pad.size() == 0) fail_now("pad_unexpected");
        else check("pad_data", m_pdata, exp_pad.pop_front());
      end
      if (m_done) begin
        dones++;
        done_cyc = cyc;
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else begin
          void'(exp_done.pop_front());
          check("done_grids", grids, mc);
          check("done_grid_pos", pos, 0);
        end
      end
    end
  end

  task automatic push_run(int w, int c);
    for (int ch = 0; ch < c; ch++) begin
      for (int i = 0; i < w * w; i++) begin
        exp_addr.push_back(ch * w * w + i);
        exp_pad.push_back(ch * w * w + i);
      end
    end
    exp_done.push_back(1);
  endtask

  task automatic run_start(int w, int c);
    push_run(w, c);
    grids  = 0;
    rd_cnt = 0;
    @(posedge clk);
    #1;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(posedge clk);
    start_cyc = cyc;
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    check("busy_after_start", m_busy, 1);
    check("first_rd_en", m_rd_en, 1);
    err_seen = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int d0 = dones;
    int t  = 0;
    while (dones == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", dones - d0, 1);
    @(negedge clk);
    check("busy_cleared", m_busy, 0);
    check("queues_drained", exp_addr.size() + exp_pad.size() + exp_done.size(), 0);
    check("err_during_run", err_seen, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_err", m_err, 0);
    check("rst_rd_en", m_rd_en, 0);
    check("rst_rd_addr", m_addr, 0);
    check("rst_pad_valid", m_pad_valid, 0);
    check("rst_pad_data", m_pdata, 0);
    check("rst_channel", m_ch, 0);
  endtask

  task automatic flush_expect();
    exp_addr.delete();
    exp_pad.delete();
    exp_done.delete();
  endtask

  initial begin
    longint lat1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();

    stall_pct = 0;
    run_start(4, 3);
    wait_done(2000);
    lat1 = done_cyc - start_cyc;

    for (int k = 0; k < 2; k++) begin
      stall_pct = int'($urandom_range(10, 60));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_start(4, 3);
      wait_done(4000);
    end

    stall_pct = 0;
    run_start(4, 3);
    repeat (3) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_done(2000);
    check("done_latency_second_start", done_cyc - start_cyc, lat1);

    stage_en = 1'b0;
    run_start(4, 3);
    repeat (100) @(negedge clk);
    check("throttle_reads", rd_cnt, 12);
    check("throttle_rd_en", m_rd_en, 0);
    check("throttle_busy", m_busy, 1);
    #1 rst_n = 1'b0;
    flush_expect();
    @(negedge clk);
    #1 rst_n = 1'b1;
    stage_en = 1'b1;

    stall_pct = 20;
    run_start(4, 3);
    begin
      int t = 0;
      while (!(m_ch == 2'd1 && m_rd_en) && t < 500) begin
        @(negedge clk);
        t++;
      end
      check("reached_channel1", m_ch, 1);
    end
    #1 rst_n = 1'b0;
    flush_expect();
    #1 check_reset_outputs();
    @(negedge clk);
    #1 rst_n = 1'b1;
    stall_pct = 0;
    run_start(4, 3);
    wait_done(2000);

    @(posedge clk);
    #1 force_pv = 1'b1;
    @(posedge clk);
    #1 force_pv = 1'b0;
    @(negedge clk);
    check("err_set_idle_pad", m_err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", m_err, 1);
    run_start(4, 3);
    check("err_cleared_by_start", m_err, 0);
    wait_done(2000);
    check("stage_depth_bound", maxq <= 12, 1);

    sel = 1'b1;
    stall_pct = 30;
    run_start(2, 1);
    wait_done(1000);
    check("small_map_reads", rd_cnt, 4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/padding_channel_sequencer.md
# padding_channel_sequencer

Sequences a multi-channel feature map from an on-chip feature buffer into the zero-padding FIFO stage (`fifo_padding_image`) of the VGG16 convolution datapath, one channel at a time. Generates feature-buffer read addresses and drives the padding stage's `i_valid`/`i_data`. Mirrors the padding stage's output stream to track how many stored pixels it has consumed, so its 3-row buffer (3·IMAGE_WIDTH entries) never overflows. Signals completion once every channel has been fully padded and emitted.

## Interface
- DATA_WIDTH, 32, pixel width
- IMAGE_WIDTH, 4, unpadded channel width = height (W)
- NUM_CHANNEL, 3, channels per feature map (C ≥ 1)
- ADDR_WIDTH, 16, feature-buffer address width
- CH_WIDTH, 2, width of o_channel; must satisfy 2^CH_WIDTH ≥ NUM_CHANNEL
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- o_busy  out  1  high from the cycle after an accepted start until o_done
- o_done  out  1  one-cycle pulse; whole map finished
- o_err  out  1  sticky protocol error
- o_rd_en  out  1  feature-buffer read strobe
- o_rd_addr  out  ADDR_WIDTH  read address; read data returns 1 cycle later
- i_rd_data  in  DATA_WIDTH  feature-buffer read data
- o_pad_valid  out  1  drives padding stage i_valid
- o_pad_data  out  DATA_WIDTH  drives padding stage i_data
- i_pad_valid  in  1  padding stage o_valid (one padded pixel per high cycle)
- o_channel  out  CH_WIDTH  channel currently being fed

## Operation
- States: IDLE, FEED, DRAIN, GAP, DONE.
- IDLE: i_start=1 → clear o_err, channel=0, issued=0, occupancy=0, out_cnt=0 → FEED.
- FEED: o_rd_en=1 when issued < W·W and occupancy < 3·W. Occupancy is the registered value, before this cycle's decrement. o_rd_addr = channel·W·W + issued, truncated to ADDR_WIDTH. On each read: issued++, occupancy++. When issued reaches W·W → DRAIN.
- Data path: o_pad_valid = o_rd_en delayed 2 cycles. o_pad_data = i_rd_data registered on the cycle after o_rd_en.
- Consumption mirror: a row/col counter over the (W+2)×(W+2) padded grid advances on every i_pad_valid, in raster order, with out_cnt++.
  - A position is interior if 1 ≤ row ≤ W and 1 ≤ col ≤ W.
  - Each interior i_pad_valid does occupancy--.
  - A read and an interior consumption in the same cycle leave occupancy unchanged.
- DRAIN: wait until out_cnt == (W+2)². Then:
  - if channel == C−1 → DONE;
  - else → GAP.
- GAP: exactly 1 cycle with o_pad_valid=0 and i_pad_valid ignored by the mirror. Then channel++, issued=0, out_cnt=0, row/col reset → FEED.
- DONE: o_done=1 for one cycle, o_busy=0 → IDLE.
- i_start outside IDLE is ignored.
- o_err set (sticky) on any of:
  - i_pad_valid while in IDLE or DONE;
  - occupancy decrement at 0;
  - out_cnt exceeding (W+2)².
- o_err is cleared only by reset or an accepted i_start. An error does not stall the FSM.

## Timing
- Reset values: o_busy=0, o_done=0, o_err=0, o_rd_en=0, o_rd_addr=0, o_pad_valid=0, o_pad_data=0, o_channel=0, state=IDLE. All counters = 0.
- Reset asserted mid-operation: immediate return to reset values, no further reads or pad strobes. The padding stage must be reset by the same rst_n.
- i_start sampled high at edge k: FEED from k+1. First o_rd_en (addr 0) in cycle k+1, first o_pad_valid in cycle k+3.
- Unthrottled per-channel read burst: W·W consecutive o_rd_en cycles.
- o_channel changes on the GAP→FEED edge only.
- o_done is asserted in the cycle after the cycle in which the last (W+2)²-th i_pad_valid of channel C−1 is counted.

## Test plan
- W=4, C=3, behavioral padding stage, 1-cycle RAM holding addr value as data.
  - Required: reads cover addresses 0..15, 16..31, 32..47, in order with no repeats.
  - Required: each channel produces 36 padded outputs, interior outputs in address order.
  - Required: a single o_done pulse, with o_err=0 throughout.
- Throttle: i_pad_valid held at 0 after start.
  - Required: exactly 12 o_rd_en pulses (addr 0..11), then o_rd_en stays 0 and o_busy stays 1.
- Second i_start pulsed mid-FEED.
  - Required: ignored; address sequence and o_done timing are identical to the single-start run.
- rst_n deasserted for 1 cycle during channel 1 FEED.
  - Required: all outputs are at reset values the same cycle.
  - Required: a subsequent start restarts at addr 0 with channel 0.
- i_pad_valid pulsed in IDLE.
  - Required: o_err=1 and stays high; the next accepted i_start clears it to 0.
- C=1, W=2.
  - Required: 4 reads (addr 0..3), 16 padded outputs, then o_done. GAP state is never entered.
